// File: rtl/util_axis_pkg.sv
// Shared types and helpers for the AXI-Stream utility blocks.
// Pure combinational helpers; no latency or backpressure of its own.
package util_axis_pkg;

   localparam int MAX_PORTS = 16;

   typedef enum logic {
      IDLE = 1'b0,
      XFER = 1'b1
   } arb_state_t;

   function automatic int idx_width(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   // First requester strictly after last_idx, wrapping modulo n; the
   // descending scan lets the nearest candidate overwrite farther ones.
   function automatic int rr_next(input logic [MAX_PORTS-1:0] req,
                                  input int last_idx,
                                  input int n);
      int res;
      int idx;
      res = last_idx;
      for (int k = MAX_PORTS; k >= 1; k--) begin
         idx = (last_idx + k) % n;
         if (k <= n && req[idx[3:0]])
            res = idx;
      end
      return res;
   endfunction

endpackage

// File: rtl/util_axis_rr_select.sv
// Round-robin priority select: request vector + last winner -> one-hot grant and index.
// Purely combinational, zero latency; no backpressure.
module util_axis_rr_select
   import util_axis_pkg::*;
#(
   parameter int NUM_PORTS = 4,
   parameter int IDX_W     = idx_width(NUM_PORTS)
) (
   input  logic [NUM_PORTS-1:0] req,
   input  logic [IDX_W-1:0]     last_idx,
   output logic                 any_req,
   output logic [NUM_PORTS-1:0] grant_oh,
   output logic [IDX_W-1:0]     grant_idx
);

   logic [MAX_PORTS-1:0] req_ext;
   int                   sel;

   always_comb begin
      req_ext                  = '0;
      req_ext[NUM_PORTS-1:0]   = req;
      any_req                  = |req;
      sel                      = rr_next(req_ext, int'(last_idx), NUM_PORTS);
      grant_idx                = IDX_W'(sel);
      grant_oh                 = '0;
      for (int i = 0; i < NUM_PORTS; i++)
         grant_oh[i] = any_req && (sel == i);
   end

endmodule

// File: rtl/util_axis_rr_arbiter.sv
// Round-robin packet-aware AXI-Stream N:1 arbiter with one registered output stage (1-cycle latency).
// A held output beat with m_axis_tready low stalls every s_axis_tready.
module util_axis_rr_arbiter
   import util_axis_pkg::*;
#(
   parameter int NUM_PORTS   = 4,
   parameter int BUS_WIDTH   = 1,
   parameter int USER_WIDTH  = 1,
   parameter int DEST_WIDTH  = 1,
   parameter int PACKET_MODE = 1
) (
   input  logic                            aclk,
   input  logic                            arstn,
   input  logic [NUM_PORTS-1:0]            s_axis_tvalid,
   output logic [NUM_PORTS-1:0]            s_axis_tready,
   input  logic [NUM_PORTS*BUS_WIDTH*8-1:0] s_axis_tdata,
   input  logic [NUM_PORTS*BUS_WIDTH-1:0]  s_axis_tkeep,
   input  logic [NUM_PORTS-1:0]            s_axis_tlast,
   input  logic [NUM_PORTS*USER_WIDTH-1:0] s_axis_tuser,
   input  logic [NUM_PORTS*DEST_WIDTH-1:0] s_axis_tdest,
   output logic                            m_axis_tvalid,
   input  logic                            m_axis_tready,
   output logic [BUS_WIDTH*8-1:0]          m_axis_tdata,
   output logic [BUS_WIDTH-1:0]            m_axis_tkeep,
   output logic                            m_axis_tlast,
   output logic [USER_WIDTH-1:0]           m_axis_tuser,
   output logic [DEST_WIDTH-1:0]           m_axis_tdest,
   output logic [NUM_PORTS-1:0]            grant
);

   localparam int IDX_W = idx_width(NUM_PORTS);
   localparam int DW    = BUS_WIDTH * 8;

   arb_state_t             state, state_nxt;
   logic [NUM_PORTS-1:0]   grant_nxt, sel_oh;
   logic [IDX_W-1:0]       gnt_idx, gnt_idx_nxt, last_idx, last_idx_nxt, sel_idx;
   logic                   any_req, out_free, accept;
   logic [DW-1:0]          sel_tdata;
   logic [BUS_WIDTH-1:0]   sel_tkeep;
   logic                   sel_tlast;
   logic [USER_WIDTH-1:0]  sel_tuser;
   logic [DEST_WIDTH-1:0]  sel_tdest;

   util_axis_rr_select #(
      .NUM_PORTS (NUM_PORTS),
      .IDX_W     (IDX_W)
   ) u_rr_select (
      .req       (s_axis_tvalid),
      .last_idx  (last_idx),
      .any_req   (any_req),
      .grant_oh  (sel_oh),
      .grant_idx (sel_idx)
   );

   assign out_free      = ~m_axis_tvalid | m_axis_tready;
   assign s_axis_tready = grant & {NUM_PORTS{out_free}};
   assign accept        = |(s_axis_tvalid & s_axis_tready);

   // grant is one-hot or zero, so an OR-reduction of masked lanes is the mux
   always_comb begin
      sel_tdata = '0;
      sel_tkeep = '0;
      sel_tlast = 1'b0;
      sel_tuser = '0;
      sel_tdest = '0;
      for (int i = 0; i < NUM_PORTS; i++) begin
         if (grant[i]) begin
            sel_tdata = sel_tdata | s_axis_tdata[i*DW +: DW];
            sel_tkeep = sel_tkeep | s_axis_tkeep[i*BUS_WIDTH +: BUS_WIDTH];
            sel_tlast = sel_tlast | s_axis_tlast[i];
            sel_tuser = sel_tuser | s_axis_tuser[i*USER_WIDTH +: USER_WIDTH];
            sel_tdest = sel_tdest | s_axis_tdest[i*DEST_WIDTH +: DEST_WIDTH];
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      grant_nxt    = grant;
      gnt_idx_nxt  = gnt_idx;
      last_idx_nxt = last_idx;
      case (state)
         IDLE: begin
            if (any_req) begin
               state_nxt   = XFER;
               grant_nxt   = sel_oh;
               gnt_idx_nxt = sel_idx;
            end
         end
         XFER: begin
            if (accept && (sel_tlast || (PACKET_MODE == 0))) begin
               state_nxt    = IDLE;
               grant_nxt    = '0;
               last_idx_nxt = gnt_idx;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         state    <= IDLE;
         grant    <= '0;
         gnt_idx  <= '0;
         last_idx <= IDX_W'(NUM_PORTS - 1);
      end else begin
         state    <= state_nxt;
         grant    <= grant_nxt;
         gnt_idx  <= gnt_idx_nxt;
         last_idx <= last_idx_nxt;
      end
   end

   // Output register drains on its own, independent of arbitration state
   always_ff @(posedge aclk or negedge arstn) begin
      if (!arstn) begin
         m_axis_tvalid <= 1'b0;
         m_axis_tdata  <= '0;
         m_axis_tkeep  <= '0;
         m_axis_tlast  <= 1'b0;
         m_axis_tuser  <= '0;
         m_axis_tdest  <= '0;
      end else if (accept) begin
         m_axis_tvalid <= 1'b1;
         m_axis_tdata  <= sel_tdata;
         m_axis_tkeep  <= sel_tkeep;
         m_axis_tlast  <= sel_tlast;
         m_axis_tuser  <= sel_tuser;
         m_axis_tdest  <= sel_tdest;
      end else if (m_axis_tready) begin
         m_axis_tvalid <= 1'b0;
      end
   end

endmodule
